// File: rtl/spi_slave_shifter_if.sv
// Parallel host side of spi_slave_shifter: tx holding-buffer
// handshake and received-word strobe.
interface spi_slave_shifter_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_load;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;

  modport master (
    output tx_data, tx_load,
    input  tx_ready, rx_data, rx_valid
  );

  modport slave (
    input  tx_data, tx_load,
    output tx_ready, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_slave_shifter.sv
// SPI target oversampling sclk/ss_n/mosi on clk.
// SPI_SLAVE_LSB_FIRST_EN selects LSB-first in both directions.
module spi_slave_shifter #(
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sclk_in,
  input  logic ss_n,
  input  logic mosi,
  output logic miso,
  output logic miso_oe,
  output logic busy,
  output logic tx_underrun,
  spi_slave_shifter_if.slave host
);

  localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    ACTIVE
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] ss_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_d;

  logic [DATA_WIDTH-1:0] tx_buf;
  logic                  buf_full;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic [DATA_WIDTH-1:0] rx_next;
  logic [DATA_WIDTH-1:0] rx_data_q;
  logic                  rx_valid_q;
  logic [CW-1:0]         bit_cnt;
  logic                  word_done;
  logic                  first_q;
  logic                  und_q;

  logic sclk_s, ss_s, mosi_s;
  logic lead, trail;
  logic start, stop, active;
  logic do_sample, do_shift, hold_first;
  logic consume;
  logic [DATA_WIDTH-1:0] next_word;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync <= {SYNC_STAGES{CPOL}};
      ss_sync   <= '0;
      mosi_sync <= '0;
      sclk_d    <= CPOL;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_s;
    end
  end

  assign lead  = (sclk_d == CPOL) && (sclk_s != CPOL);
  assign trail = (sclk_d != CPOL) && (sclk_s == CPOL);

  always_ff @(posedge clk) begin
    if (reset) state_q <= WAIT_IDLE;
    else       state_q <= state_d;
  end

  // WAIT_IDLE refuses to join a frame already in progress
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    stop    = 1'b0;
    unique case (state_q)
      WAIT_IDLE: if (ss_s) state_d = IDLE;
      IDLE: begin
        if (!ss_s) begin
          state_d = ACTIVE;
          start   = 1'b1;
        end
      end
      ACTIVE: begin
        if (ss_s) begin
          state_d = IDLE;
          stop    = 1'b1;
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  assign active     = (state_q == ACTIVE);
  assign do_sample  = active && !ss_s &&
                      (CPHA ? trail : lead);
  assign do_shift   = active && !ss_s &&
                      (CPHA ? lead : trail);
  assign hold_first = CPHA && first_q;
  assign consume    = start ||
                      (do_shift && !hold_first && word_done);
  assign next_word  = buf_full ? tx_buf : '0;

`ifdef SPI_SLAVE_LSB_FIRST_EN
  assign rx_next = {mosi_s, rx_shift[DATA_WIDTH-1:1]};
  assign miso    = active & tx_shift[0];
`else
  assign rx_next = {rx_shift[DATA_WIDTH-2:0], mosi_s};
  assign miso    = active & tx_shift[DATA_WIDTH-1];
`endif

  assign miso_oe       = active;
  assign busy          = active;
  assign tx_underrun   = und_q;
  assign host.tx_ready = !buf_full;
  assign host.rx_data  = rx_data_q;
  assign host.rx_valid = rx_valid_q;

  // Consume sees the old buffer, so a same-cycle load survives
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_buf   <= '0;
      buf_full <= 1'b0;
    end else begin
      if (consume) buf_full <= 1'b0;
      if (host.tx_load && !buf_full) begin
        tx_buf   <= host.tx_data;
        buf_full <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_shift <= '0;
      und_q    <= 1'b0;
    end else begin
      und_q <= consume && !buf_full;
      if (stop) begin
        tx_shift <= '0;
      end else if (consume) begin
        tx_shift <= next_word;
      end else if (do_shift && !hold_first) begin
`ifdef SPI_SLAVE_LSB_FIRST_EN
        tx_shift <= tx_shift >> 1;
`else
        tx_shift <= tx_shift << 1;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_shift   <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      bit_cnt    <= '0;
      word_done  <= 1'b0;
      first_q    <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (start || stop) begin
        bit_cnt   <= '0;
        word_done <= 1'b0;
        first_q   <= start;
      end else begin
        if (do_shift) begin
          first_q <= 1'b0;
          if (!hold_first) word_done <= 1'b0;
        end
        if (do_sample) begin
          rx_shift <= rx_next;
          if (bit_cnt == LAST) begin
            bit_cnt    <= '0;
            word_done  <= 1'b1;
            rx_data_q  <= rx_next;
            rx_valid_q <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_shifter.sv
// Directed bench: mode-0 target plus a CPOL1/CPHA1 target.
// Bit order follows SPI_SLAVE_LSB_FIRST_EN.
module tb_spi_slave_shifter;

`ifdef SPI_SLAVE_LSB_FIRST_EN
  localparam bit LSB = 1'b1;
`else
  localparam bit LSB = 1'b0;
`endif
  localparam int HC = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sclk0 = 1'b0, ss0 = 1'b1, mosi0 = 1'b0;
  logic sclk1 = 1'b1, ss1 = 1'b1, mosi1 = 1'b0;
  logic miso0, oe0, busy0, und0;
  logic miso1, oe1, busy1, und1;

  int nchk = 0;
  int npass = 0;
  int rxv0 = 0, rxv1 = 0, undc0 = 0, undc1 = 0;
  int r, u;
  logic [7:0] mi, mi1, mi2, mi3;

  spi_slave_shifter_if #(.DATA_WIDTH(8)) h0 ();
  spi_slave_shifter_if #(.DATA_WIDTH(8)) h1 ();

  spi_slave_shifter #(
    .CPOL(1'b0), .CPHA(1'b0),
    .DATA_WIDTH(8), .SYNC_STAGES(2)
  ) dut0 (
    .clk(clk), .reset(reset),
    .sclk_in(sclk0), .ss_n(ss0), .mosi(mosi0),
    .miso(miso0), .miso_oe(oe0), .busy(busy0),
    .tx_underrun(und0), .host(h0)
  );

  spi_slave_shifter #(
    .CPOL(1'b1), .CPHA(1'b1),
    .DATA_WIDTH(8), .SYNC_STAGES(2)
  ) dut1 (
    .clk(clk), .reset(reset),
    .sclk_in(sclk1), .ss_n(ss1), .mosi(mosi1),
    .miso(miso1), .miso_oe(oe1), .busy(busy1),
    .tx_underrun(und1), .host(h1)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (h0.rx_valid) rxv0++;
    if (h1.rx_valid) rxv1++;
    if (und0) undc0++;
    if (und1) undc1++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check(string tag, logic [31:0] obs,
                       logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0h expected %0h",
                tag, obs, exp);
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_sclk(int sel, logic v);
    if (sel == 0) sclk0 = v;
    else sclk1 = v;
  endtask

  task automatic set_ss(int sel, logic v);
    if (sel == 0) ss0 = v;
    else ss1 = v;
  endtask

  task automatic set_mosi(int sel, logic v);
    if (sel == 0) mosi0 = v;
    else mosi1 = v;
  endtask

  task automatic load(int sel, logic [7:0] d);
    @(negedge clk);
    if (sel == 0) begin
      h0.tx_data = d;
      h0.tx_load = 1'b1;
    end else begin
      h1.tx_data = d;
      h1.tx_load = 1'b1;
    end
    @(negedge clk);
    h0.tx_load = 1'b0;
    h1.tx_load = 1'b0;
  endtask

  task automatic spi_begin(int sel);
    @(negedge clk);
    set_ss(sel, 1'b0);
    cyc(HC);
  endtask

  task automatic spi_end(int sel);
    cyc(HC);
    set_ss(sel, 1'b1);
    cyc(2 * HC);
  endtask

  task automatic spi_word(int sel, logic cpol, logic cpha,
                          logic [7:0] mo, int nbits,
                          output logic [7:0] mi_o);
    int idx;
    mi_o = '0;
    for (int i = 0; i < nbits; i++) begin
      idx = LSB ? i : 7 - i;
      if (!cpha) begin
        set_mosi(sel, mo[idx]);
        cyc(HC);
        mi_o[idx] = (sel == 0) ? miso0 : miso1;
        set_sclk(sel, ~cpol);
        cyc(HC);
        set_sclk(sel, cpol);
      end else begin
        set_sclk(sel, ~cpol);
        set_mosi(sel, mo[idx]);
        cyc(HC);
        mi_o[idx] = (sel == 0) ? miso0 : miso1;
        set_sclk(sel, cpol);
        cyc(HC);
      end
    end
  endtask

  initial begin
    h0.tx_data = '0;
    h0.tx_load = 1'b0;
    h1.tx_data = '0;
    h1.tx_load = 1'b0;

    cyc(3);
    check("rst_miso", miso0, 0);
    check("rst_oe", oe0, 0);
    check("rst_busy", busy0, 0);
    check("rst_tx_ready", h0.tx_ready, 1);
    check("rst_rx_data", h0.rx_data, 0);
    check("rst_rx_valid", h0.rx_valid, 0);
    check("rst_underrun", und0, 0);
    check("rst_miso1", miso1, 0);
    reset = 1'b0;
    cyc(6);

    // mode 0 single word
    load(0, 8'hA5);
    check("t1_tx_ready_full", h0.tx_ready, 0);
    r = rxv0;
    u = undc0;
    spi_begin(0);
    check("t1_busy", busy0, 1);
    check("t1_oe", oe0, 1);
    check("t1_buf_freed", h0.tx_ready, 1);
    spi_word(0, 1'b0, 1'b0, 8'h3C, 8, mi);
    spi_end(0);
    check("t1_miso", mi, 8'hA5);
    check("t1_rx_data", h0.rx_data, 8'h3C);
    check("t1_rx_valid_cnt", rxv0 - r, 1);
    check("t1_underrun_cnt", undc0 - u, 1);
    check("t1_busy_end", busy0, 0);
    check("t1_oe_end", oe0, 0);

    // back-to-back words, mid-word load, ignored load
    load(0, 8'h12);
    r = rxv0;
    u = undc0;
    spi_begin(0);
    fork
      spi_word(0, 1'b0, 1'b0, 8'h56, 8, mi1);
      begin
        cyc(6 * HC);
        load(0, 8'h34);
        check("t2_ready_after_load", h0.tx_ready, 0);
        load(0, 8'h99);
      end
    join
    check("t2_rx_w1", h0.rx_data, 8'h56);
    spi_word(0, 1'b0, 1'b0, 8'h78, 8, mi2);
    check("t2_rx_w2", h0.rx_data, 8'h78);
    spi_word(0, 1'b0, 1'b0, 8'h9A, 8, mi3);
    spi_end(0);
    check("t2_miso_w1", mi1, 8'h12);
    check("t2_miso_w2", mi2, 8'h34);
    check("t2_miso_w3", mi3, 8'h00);
    check("t2_rx_w3", h0.rx_data, 8'h9A);
    check("t2_rx_valid_cnt", rxv0 - r, 3);
    check("t2_underrun_cnt", undc0 - u, 2);
    check("t2_tx_ready_end", h0.tx_ready, 1);

    // aborted partial word
    r = rxv0;
    spi_begin(0);
    spi_word(0, 1'b0, 1'b0, 8'hFF, 5, mi);
    spi_end(0);
    check("t3_no_rx_valid", rxv0 - r, 0);
    check("t3_busy", busy0, 0);
    check("t3_rx_held", h0.rx_data, 8'h9A);
    spi_begin(0);
    spi_word(0, 1'b0, 1'b0, 8'h81, 8, mi);
    spi_end(0);
    check("t3_rx_data", h0.rx_data, 8'h81);
    check("t3_rx_valid_cnt", rxv0 - r, 1);

    // CPOL1/CPHA1 target
    load(1, 8'hF0);
    r = rxv1;
    u = undc1;
    spi_begin(1);
    check("t4_busy", busy1, 1);
    spi_word(1, 1'b1, 1'b1, 8'h0F, 8, mi);
    spi_end(1);
    check("t4_miso", mi, 8'hF0);
    check("t4_rx_data", h1.rx_data, 8'h0F);
    check("t4_rx_valid_cnt", rxv1 - r, 1);
    check("t4_underrun_cnt", undc1 - u, 0);

    // reset inside a frame
    spi_begin(0);
    spi_word(0, 1'b0, 1'b0, 8'hC3, 3, mi);
    @(negedge clk);
    reset = 1'b1;
    cyc(2);
    check("t5_oe_in_reset", oe0, 0);
    check("t5_rx_data_reset", h0.rx_data, 0);
    reset = 1'b0;
    r = rxv0;
    spi_word(0, 1'b0, 1'b0, 8'hFF, 8, mi);
    check("t5_no_rx_valid", rxv0 - r, 0);
    check("t5_oe_blocked", oe0, 0);
    check("t5_miso_blocked", mi, 8'h00);
    spi_end(0);
    spi_begin(0);
    check("t5_busy_again", busy0, 1);
    spi_word(0, 1'b0, 1'b0, 8'hC3, 8, mi);
    spi_end(0);
    check("t5_rx_data", h0.rx_data, 8'hC3);
    check("t5_rx_valid_cnt", rxv0 - r, 1);

    // single set bit shows bit order on the wire
    load(0, 8'h01);
    spi_begin(0);
    check("t6_first_bit", miso0, LSB ? 1 : 0);
    spi_word(0, 1'b0, 1'b0, 8'h01, 8, mi);
    spi_end(0);
    check("t6_miso", mi, 8'h01);
    check("t6_rx_data", h0.rx_data, 8'h01);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
